// File: rtl/envelope_follower_if.sv
// rtl/envelope_follower_if.sv - sample-in / envelope-out bundle for envelope_follower
//
// Purpose: groups the sample strobe, the mode select and the envelope result
//   so the producer and the envelope follower share one connection.
// Signals:
//   sample_valid_in  qualifies sample_in for one cycle
//   sample_in        signed two's-complement sample, SAMPLE_WIDTH bits
//   mode             0 = moving average, 1 = peak with release
//   out_valid        one-cycle pulse when out_sample updates
//   out_sample       unsigned envelope, held between updates
//   settled          sticky, high once a full window has been accepted
// Modports:
//   master  sample source / consumer of the envelope
//   slave   the envelope follower itself
interface envelope_follower_if #(
  parameter int SAMPLE_WIDTH = 24
);
  logic                    sample_valid_in;
  logic [SAMPLE_WIDTH-1:0] sample_in;
  logic                    mode;
  logic                    out_valid;
  logic [SAMPLE_WIDTH-1:0] out_sample;
  logic                    settled;

  modport master (
    output sample_valid_in,
    output sample_in,
    output mode,
    input  out_valid,
    input  out_sample,
    input  settled
  );

  modport slave (
    input  sample_valid_in,
    input  sample_in,
    input  mode,
    output out_valid,
    output out_sample,
    output settled
  );
endinterface

// File: rtl/envelope_follower.sv
// rtl/envelope_follower.sv - rectifying moving-average / peak-release envelope detector
//
// Purpose: rectifies each accepted signed sample and tracks its envelope two
//   ways at once: a 2^LOG2_DEPTH-window moving average and a peak follower with
//   exponential release. mode picks which one loads out_sample; both paths are
//   updated on every accepted sample so switching never shows a transient.
// Parameters:
//   SAMPLE_WIDTH  width of input and output samples
//   LOG2_DEPTH    log2 of the moving-average window (1..6)
//   DECAY_SHIFT   peak release: env loses env>>DECAY_SHIFT per sample
// Ports:
//   sample_clock  clock, rising edge
//   rst           synchronous, active-high reset
//   bus           envelope_follower_if.slave (sample in, envelope out)
module envelope_follower #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int LOG2_DEPTH   = 3,
  parameter int DECAY_SHIFT  = 4
) (
  input  logic                sample_clock,
  input  logic                rst,
  envelope_follower_if.slave  bus
);

  localparam int DEPTH  = 1 << LOG2_DEPTH;
  localparam int SUM_W  = SAMPLE_WIDTH + LOG2_DEPTH;
  localparam int FILL_W = LOG2_DEPTH + 1;

  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(DEPTH);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(DEPTH - 1);

  logic [SAMPLE_WIDTH-1:0] ring [DEPTH];
  logic [LOG2_DEPTH-1:0]   wptr;
  logic [SUM_W-1:0]        sum;
  logic [SAMPLE_WIDTH-1:0] env;
  logic [FILL_W-1:0]       fill;
  logic                    out_valid_q;
  logic [SAMPLE_WIDTH-1:0] out_sample_q;
  logic                    settled_q;

  logic [SAMPLE_WIDTH-1:0] mag;
  logic [SUM_W-1:0]        sum_next;
  logic [SAMPLE_WIDTH-1:0] avg;
  logic [SAMPLE_WIDTH-1:0] decay;
  logic [SAMPLE_WIDTH-1:0] env_next;

  always_comb begin
    // Negating the most-negative value wraps back to 2^(W-1), which is
    // exactly the magnitude wanted when read as unsigned.
    mag = bus.sample_in[SAMPLE_WIDTH-1] ? (~bus.sample_in) + SAMPLE_WIDTH'(1)
                                        : bus.sample_in;

    // The sum holds at most DEPTH full-scale magnitudes, so SUM_W bits
    // never overflow; the subtraction retires the slot about to be rewritten.
    sum_next = sum + SUM_W'(mag) - SUM_W'(ring[wptr]);
    avg      = sum_next[SUM_W-1:LOG2_DEPTH];

    decay    = env >> DECAY_SHIFT;
    env_next = env;
    if (mag >= env) begin
      env_next = mag;
    end else if (decay != '0) begin
      env_next = env - decay;
    end else if (env != '0) begin
      // Small envelopes would stall with a zero shift; step down by one so
      // the release always reaches zero.
      env_next = env - SAMPLE_WIDTH'(1);
    end
  end

  always_ff @(posedge sample_clock) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ring[i] <= '0;
      end
      wptr         <= '0;
      sum          <= '0;
      env          <= '0;
      fill         <= '0;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
      settled_q    <= 1'b0;
    end else begin
      out_valid_q <= bus.sample_valid_in;
      if (bus.sample_valid_in) begin
        ring[wptr] <= mag;
        wptr       <= wptr + LOG2_DEPTH'(1);
        sum        <= sum_next;
        env        <= env_next;
        if (fill != FILL_MAX) begin
          fill <= fill + FILL_W'(1);
        end
        if (fill == FILL_LAST) begin
          settled_q <= 1'b1;
        end
        out_sample_q <= bus.mode ? env_next : avg;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_sample = out_sample_q;
  assign bus.settled    = settled_q;

endmodule

// File: tb/tb_envelope_follower.sv
// tb/tb_envelope_follower.sv - self-checking bench for envelope_follower
module tb_envelope_follower;

  localparam int W     = 24;
  localparam int LOG2D = 3;
  localparam int SHIFT = 4;
  localparam int DEPTH = 1 << LOG2D;

  logic sample_clock;
  logic rst;

  envelope_follower_if #(.SAMPLE_WIDTH(W)) bus ();

  envelope_follower #(
    .SAMPLE_WIDTH(W),
    .LOG2_DEPTH  (LOG2D),
    .DECAY_SHIFT (SHIFT)
  ) dut (
    .sample_clock(sample_clock),
    .rst         (rst),
    .bus         (bus)
  );

  initial sample_clock = 1'b0;
  always #5 sample_clock = ~sample_clock;

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: last DEPTH magnitudes kept as plain integers (newest
  // first), envelope and outputs tracked with ordinary arithmetic.
  longint hist [DEPTH];
  longint m_env;
  int     m_count;
  longint m_out;
  bit     m_valid;
  bit     m_settled;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) hist[i] = 0;
    m_env     = 0;
    m_count   = 0;
    m_out     = 0;
    m_valid   = 0;
    m_settled = 0;
  endtask

  task automatic model_accept(input logic signed [W-1:0] s, input bit m);
    longint v;
    longint mag;
    longint total;
    v   = s;
    mag = (v < 0) ? -v : v;
    for (int i = DEPTH - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = mag;
    total = 0;
    for (int i = 0; i < DEPTH; i++) total += hist[i];
    if (mag >= m_env)                 m_env = mag;
    else if (m_env / (2**SHIFT) > 0)  m_env = m_env - m_env / (2**SHIFT);
    else if (m_env > 0)               m_env = m_env - 1;
    if (m_count < DEPTH) m_count++;
    m_settled = (m_count >= DEPTH);
    m_out     = m ? m_env : total / DEPTH;
    m_valid   = 1;
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the
  // rising edge, then compare against the model.
  task automatic step(input bit v, input logic signed [W-1:0] s, input bit m, input bit r);
    @(negedge sample_clock);
    rst                 = r;
    bus.sample_valid_in = v;
    bus.sample_in       = s;
    bus.mode            = m;
    @(posedge sample_clock);
    #1;
    if (r)      model_reset();
    else if (v) model_accept(s, m);
    else        m_valid = 0;
    check("out_valid",  longint'(bus.out_valid),  longint'(m_valid));
    check("out_sample", longint'(bus.out_sample), m_out);
    check("settled",    longint'(bus.settled),    longint'(m_settled));
  endtask

  initial begin
    logic signed [W-1:0] s;
    rst                 = 1'b1;
    bus.sample_valid_in = 1'b0;
    bus.sample_in       = '0;
    bus.mode            = 1'b0;
    model_reset();

    // Reset state
    step(0, 0, 0, 1);
    check("reset_out", longint'(bus.out_sample), 0);
    check("reset_settled", longint'(bus.settled), 0);

    // Ramp of 800s
    for (int k = 1; k <= 12; k++) begin
      step(1, 800, 0, 0);
      check("ramp_out", longint'(bus.out_sample), (k < 8) ? 100 * k : 800);
      check("ramp_settled", longint'(bus.settled), (k >= 8) ? 1 : 0);
    end

    // Mid-stream reset with a valid sample in the same cycle
    step(1, 800, 0, 1);
    check("midrst_out", longint'(bus.out_sample), 0);
    check("midrst_settled", longint'(bus.settled), 0);
    check("midrst_valid", longint'(bus.out_valid), 0);
    step(1, 800, 0, 0);
    check("restart_out", longint'(bus.out_sample), 100);

    // Rectification
    step(0, 0, 0, 1);
    for (int k = 1; k <= 16; k++) begin
      step(1, (k % 2) ? 24'sd1000 : -24'sd1000, 0, 0);
      if (k >= 8) check("rect_out", longint'(bus.out_sample), 1000);
    end
    for (int k = 1; k <= 8; k++) step(1, 24'sh800000, 0, 0);
    check("rect_minneg", longint'(bus.out_sample), 64'h800000);

    // Peak release from 1600
    step(0, 0, 0, 1);
    step(1, 1600, 1, 0);
    check("peak_0", longint'(bus.out_sample), 1600);
    step(1, 0, 1, 0);
    check("peak_1", longint'(bus.out_sample), 1500);
    step(1, 0, 1, 0);
    check("peak_2", longint'(bus.out_sample), 1407);
    for (int k = 0; k < 20; k++) step(1, 0, 1, 0);

    // Small impulse decays by one to zero and holds
    step(0, 0, 0, 1);
    step(1, 10, 1, 0);
    for (int k = 1; k <= 13; k++) begin
      step(1, 0, 1, 0);
      check("peak_small", longint'(bus.out_sample), (k <= 10) ? 10 - k : 0);
    end

    // Mode switch only takes effect on an accept
    step(0, 0, 0, 1);
    step(1, 1600, 0, 0);
    check("sw_avg0", longint'(bus.out_sample), 200);
    step(1, 0, 0, 0);
    check("sw_avg1", longint'(bus.out_sample), 200);
    step(0, 0, 1, 0);
    check("sw_hold1", longint'(bus.out_sample), 200);
    step(1, 0, 1, 0);
    check("sw_peak", longint'(bus.out_sample), 1407);
    step(0, 0, 0, 0);
    check("sw_hold0", longint'(bus.out_sample), 1407);
    step(1, 0, 0, 0);
    check("sw_avg2", longint'(bus.out_sample), 200);

    // Valid gaps
    step(0, 0, 0, 1);
    for (int k = 1; k <= 8; k++) begin
      step(1, 800, 0, 0);
      check("gap_out", longint'(bus.out_sample), 100 * k);
      for (int g = 0; g < 3; g++) begin
        step(0, 0, 0, 0);
        check("gap_idle_valid", longint'(bus.out_valid), 0);
        check("gap_idle_out", longint'(bus.out_sample), 100 * k);
      end
    end
    check("gap_settled", longint'(bus.settled), 1);

    // Randomised run against the model
    step(0, 0, 0, 1);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0)      s = 24'sh800000;
      else if ($urandom_range(0, 3) == 0)  s = W'($urandom_range(0, 40)) - 24'sd20;
      else                                 s = W'($urandom);
      step($urandom_range(0, 9) < 7, s, 1'($urandom), $urandom_range(0, 199) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/envelope_follower.md
# envelope_follower

Parametrised, multi-mode envelope detector for signed audio samples; successor to the fixed 8-tap unsigned envelope averager. It rectifies each incoming sample and tracks its envelope either as a power-of-two-window moving average or as a peak follower with exponential release. It sits in the sample-rate (96 kHz) domain after the sample source and feeds level/threshold logic downstream. Inputs are qualified by a valid strobe, so it runs on a strobed fast clock or with valid tied high at the sample clock.

## Interface
- SAMPLE_WIDTH, 24, width of input and output samples.
- LOG2_DEPTH, 3, log2 of the moving-average window; window DEPTH = 2^LOG2_DEPTH; legal range 1..6.
- DECAY_SHIFT, 4, peak-mode release rate; the envelope loses env>>DECAY_SHIFT per sample; legal range 1..SAMPLE_WIDTH-1.
- sample_clock  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- sample_valid_in  in  1  qualifies sample_in for one cycle.
- sample_in  in  SAMPLE_WIDTH  two's-complement signed sample.
- mode  in  1  0 = moving average, 1 = peak with release.
- out_valid  out  1  one-cycle pulse when out_sample updates.
- out_sample  out  SAMPLE_WIDTH  unsigned envelope, registered, held between updates.
- settled  out  1  high once DEPTH samples have been accepted since reset; sticky.

## Operation
- Accept: a sample is accepted on any rising edge with sample_valid_in=1 and rst=0. No other state changes on other cycles.
- Rectify: mag = |sample_in| as unsigned SAMPLE_WIDTH bits. Most-negative input -2^(W-1) gives mag = 2^(W-1) exactly, with no saturation.
- Average path: DEPTH-entry ring buffer of magnitudes, zeroed by reset, with a write pointer that wraps DEPTH-1 -> 0.
  - Running sum of width SAMPLE_WIDTH+LOG2_DEPTH; on accept: sum_next = sum + mag - buf[wptr], then buf[wptr] = mag.
  - avg = sum_next >> LOG2_DEPTH, truncating. The sum cannot overflow.
- Peak path: register env (SAMPLE_WIDTH bits, reset 0). On accept:
  - mag >= env: env = mag (instant attack).
  - else if env>>DECAY_SHIFT is nonzero: env = env - (env>>DECAY_SHIFT).
  - else if env > 0: env = env - 1, so the envelope always reaches 0.
  - else env stays 0.
- Both paths update on every accepted sample regardless of mode. mode only selects which value loads out_sample, so a mode switch is glitch-free and both paths are always warm.
- mode is sampled on the accepting edge. A change with no accepted sample does not alter out_sample.
- Fill counter: counts accepted samples up to DEPTH and saturates there. settled is 1 from the update of the DEPTH-th accepted sample onward.
- Reset (any time, including mid-stream): buffer, sum, wptr, env, fill counter, out_sample, out_valid and settled all go to 0 on the next edge. A sample_valid_in in the same cycle as rst is dropped.

## Timing
- Latency is 1 cycle: a sample accepted at edge n produces out_sample and out_valid=1 visible after edge n.
- The average result includes the current sample: out = floor((mag[n] + ... + mag[n-DEPTH+1]) / DEPTH). Slots not yet written since reset count as 0.
- out_valid is high for exactly one cycle per accepted sample. Back-to-back valid inputs give back-to-back pulses.
- Throughput is one sample per cycle; there is no backpressure.
- Reset values: out_sample=0, out_valid=0, settled=0.

## Test plan
- Ramp: default parameters, mode 0, reset, then sample_in=800 valid every cycle -> out_sample 100,200,...,800 on pulses 1..8; settled rises with the 8th pulse; output then stays 800.
- Rectification: mode 0, alternating +1000/-1000 for 16 samples -> 1000 from the 8th output onward. Eight samples of -8388608 -> 0x800000.
- Peak release: mode 1, DECAY_SHIFT=4, one sample 1600 then zeros -> 1600, 1500, 1407, ... Separately, one sample 10 then zeros -> 10, 9, ..., 0, then holds 0.
- Mode switch: run both paths with a 1600 impulse, toggle mode between accepts -> out_sample unchanged until the next accept, then shows the other path's current value with no transient.
- Valid gaps: insert 3 idle cycles between samples -> out_valid stays 0 and out_sample holds; results match the gap-free sequence.
- Mid-stream reset: after settling at 800, assert rst for 1 cycle with valid=1 -> out_sample=0, settled=0, that sample dropped; the ramp restarts at 100.
